binary_oct: RTL

BINARY_OCT -- requirements
Module: binary_oct

---
 rtl/binary_oct.sv | 101 ++++++++++
 1 files changed

// File: rtl/binary_oct.sv
// binary_oct: 3-to-8 one-hot decoder with a timed sweep mode.
// A single decode loads y/code_out from the input code with one-edge latency.
// A sweep walks the one-hot bit from code 0 to code 7, holding each code for
// STEP_CYCLES clocks, then pulses done for one cycle and returns to IDLE.
module binary_oct #(
    parameter int STEP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] code,
    output logic       in_ready,
    input  logic       sweep_start,
    output logic [7:0] y,
    output logic [2:0] code_out,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Divider value on the last cycle a code is held during a sweep.
    localparam logic [7:0] DIV_LAST = 8'(STEP_CYCLES - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] div_reg;

    logic accept_decode;
    logic accept_sweep;
    logic step_end;

    // A decode always beats a simultaneous sweep request.
    assign accept_decode = (state_reg == IDLE) && in_valid;
    assign accept_sweep  = (state_reg == IDLE) && !in_valid && sweep_start;
    assign step_end      = (state_reg == SWEEP) && (div_reg == DIV_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: leave SWEEP only after code 7 has been held its full time.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept_sweep) state_next = SWEEP;
            SWEEP:   if (step_end && (code_out == 3'd7)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready = (state_reg == IDLE);
        busy     = (state_reg == SWEEP) || (state_reg == DONE);
        done     = (state_reg == DONE);
    end

    // Datapath: one-hot output, its index, the decode strobe and the step divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y         <= 8'h00;
            code_out  <= 3'd0;
            out_valid <= 1'b0;
            div_reg   <= 8'd0;
        end else begin
            out_valid <= accept_decode;
            if (accept_decode) begin
                y        <= 8'd1 << code;
                code_out <= code;
            end else if (accept_sweep) begin
                y        <= 8'h01;
                code_out <= 3'd0;
                div_reg  <= 8'd0;
            end else if (state_reg == SWEEP) begin
                if (step_end) begin
                    div_reg <= 8'd0;
                    // Code 7 is terminal: hold it rather than wrapping to 0.
                    if (code_out != 3'd7) begin
                        y        <= y << 1;
                        code_out <= code_out + 3'd1;
                    end
                end else begin
                    div_reg <= div_reg + 8'd1;
                end
            end
        end
    end

endmodule
